// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : shared core constants and the fetch-queue entry type
// Revision: 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int IMEM_AW = 6;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/m_fetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m_fetch_fifo : DEPTH-entry {pc, inst} queue with push/pop/flush and count
// Revision: 1.0
// ----------------------------------------------------------------------------
module m_fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  fetch_entry_t          push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output fetch_entry_t          head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             w_do_push, w_do_pop;

  assign w_do_push = push_i & ~flush_i & (count_q != (AW+1)'(DEPTH));
  assign w_do_pop  = pop_i  & ~flush_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/m_ifetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m_ifetch : instruction fetch with 1-cycle imem, redirect flush, output queue
// Revision: 1.0
// ----------------------------------------------------------------------------
module m_ifetch
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               w_clk,
  input  logic               w_rst_n,
  input  logic               w_redirect,
  input  logic [XLEN-1:0]    w_redirect_pc,
  output logic               w_imem_req,
  output logic [IMEM_AW-1:0] w_imem_addr,
  input  logic [XLEN-1:0]    w_imem_rdata,
  output logic               w_out_valid,
  input  logic               w_out_ready,
  output logic [XLEN-1:0]    w_out_pc,
  output logic [XLEN-1:0]    w_out_inst
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic            inflight_q;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  logic            w_empty, w_pop, w_push, w_req;
  fetch_entry_t    w_head, w_push_data;
  logic            w_unused_rpc;

  assign w_unused_rpc = ^w_redirect_pc[1:0];

  assign w_out_valid = ~w_empty;
  assign w_pop       = w_out_valid & w_out_ready;
  assign w_push      = inflight_q & ~w_redirect;

  // Occupancy nets out this cycle's pop so a draining consumer sustains one
  // request per cycle; slot accounting still never exceeds DEPTH.
  assign w_occ = {1'b0, w_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, w_pop};
  assign w_req = w_rst_n & ~w_redirect & (w_occ < (CW+1)'(DEPTH));

  assign w_imem_req  = w_req;
  assign w_imem_addr = r_fetch_pc[IMEM_AW+1:2];

  assign w_push_data.pc   = req_pc_q;
  assign w_push_data.inst = w_imem_rdata;

  assign w_out_pc   = w_out_valid ? w_head.pc   : '0;
  assign w_out_inst = w_out_valid ? w_head.inst : '0;

  always_comb begin
    fetch_pc_d = r_fetch_pc;
    if (w_redirect)  fetch_pc_d = {w_redirect_pc[XLEN-1:2], 2'b00};
    else if (w_req)  fetch_pc_d = r_fetch_pc + 32'd4;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fetch_pc <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      r_fetch_pc <= fetch_pc_d;
      inflight_q <= w_req;
      if (w_req) req_pc_q <= r_fetch_pc;
    end
  end

  m_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (w_clk),
    .rst_ni      (w_rst_n),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .flush_i     (w_redirect),
    .head_o      (w_head),
    .count_o     (w_count),
    .empty_o     (w_empty)
  );

endmodule
`default_nettype wire
